// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative multiply/divide unit covering the RV32M set (MUL, MULH, MULHSU,
//   MULHU, DIV, DIVU, REM, REMU). Works on operand magnitudes: shift-add for
//   multiply, restoring division for divide. A final cycle applies the sign
//   and the special cases. Latency is XLEN+1 cycles from accept to done,
//   whatever the operand values.
//
// Ports
//   clock   rising-edge clock
//   reset   asynchronous, active-high reset
//   start   request, sampled only while idle
//   funct3  RV32M operation select, latched on accept
//   op_a    rs1 value (multiplicand / dividend), latched on accept
//   op_b    rs2 value (multiplier / divisor), latched on accept
//   flush   synchronous abort of the in-flight operation
//   busy    high from the accept edge through the done cycle
//   done    one-cycle pulse, result valid in that cycle
//   result  final value, held until the next accept or reset
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; done pulses here for one cycle after FIX
// CALC   | one operand bit per cycle, XLEN cycles
// FIX    | sign correction, special cases, output select, result register

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [2:0]      op_q;
  logic            neg_q;
  logic            div_zero_q;
  logic            div_ovf_q;
  logic [CW-1:0]   cnt_q;
  // hold_q: multiplicand (multiply) or divisor (divide), constant during CALC.
  // hi_q:   upper product half / partial remainder.
  // lo_q:   multiplier shifting out / dividend shifting out, quotient in.
  logic [XLEN-1:0] hold_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;

  // accept-side decode
  logic            a_sgn;
  logic            b_sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            res_neg;
  logic            ovf_in;

  // iteration datapath
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_borrow;

  // fix-up datapath
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_val;

  assign busy = (state != S_IDLE) | done;

  always_comb begin
    a_sgn   = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
              (funct3 == F_DIV)  || (funct3 == F_REM);
    b_sgn   = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    a_neg   = a_sgn & op_a[XLEN-1];
    b_neg   = b_sgn & op_b[XLEN-1];
    // the most negative value maps onto itself, which is the correct
    // unsigned magnitude 2^(XLEN-1)
    abs_a   = a_neg ? -op_a : op_a;
    abs_b   = b_neg ? -op_b : op_b;
    // remainder takes the dividend's sign, everything else the xor
    res_neg = (funct3 == F_REM) ? a_neg : (a_neg ^ b_neg);
    ovf_in  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
              (op_a == SMIN) && (op_b == {XLEN{1'b1}});
  end

  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, hold_q} : {(XLEN+1){1'b0}});
    div_shift  = {hi_q, lo_q[XLEN-1]};
    // partial remainder stays below the divisor, so XLEN+1 bits is enough
    // and the top bit of the difference is the borrow
    div_diff   = div_shift - {1'b0, hold_q};
    div_borrow = div_diff[XLEN];
  end

  always_comb begin
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot_fix = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_q ? -hi_q : hi_q;
    fix_val  = '0;
    case (op_q)
      F_MUL:                      fix_val = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU: begin
        if (div_zero_q)      fix_val = {XLEN{1'b1}};
        else if (div_ovf_q)  fix_val = SMIN;
        else                 fix_val = quot_fix;
      end
      F_REM, F_REMU: begin
        // with a zero divisor every trial subtract succeeds and the
        // remainder ends as |op_a|; the dividend sign restores op_a
        if (div_ovf_q)       fix_val = '0;
        else                 fix_val = rem_fix;
      end
      default:                    fix_val = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      result     <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      hold_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              op_q       <= funct3;
              neg_q      <= res_neg;
              div_zero_q <= (op_b == '0);
              div_ovf_q  <= ovf_in;
              hold_q     <= funct3[2] ? abs_b : abs_a;
              lo_q       <= funct3[2] ? abs_a : abs_b;
              hi_q       <= '0;
              cnt_q      <= CW'(XLEN);
              state      <= S_CALC;
            end
          end
          S_CALC: begin
            if (op_q[2]) begin
              hi_q <= div_borrow ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], ~div_borrow};
            end else begin
              hi_q <= mul_sum[XLEN:1];
              lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
            end
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state <= S_FIX;
          end
          S_FIX: begin
            result <= fix_val;
            done   <= 1'b1;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        start_w, flush_w, busy_w, done_w;
  logic [2:0]  f3_w;
  logic [31:0] a_w, b_w, res_w;

  logic        start_n, flush_n, busy_n, done_n;
  logic [2:0]  f3_n;
  logic [7:0]  a_n, b_n, res_n;

  muldiv_unit #(.XLEN(32)) dut_w (
    .clock(clock), .reset(reset), .start(start_w), .funct3(f3_w),
    .op_a(a_w), .op_b(b_w), .flush(flush_w),
    .busy(busy_w), .done(done_w), .result(res_w)
  );

  muldiv_unit #(.XLEN(8)) dut_n (
    .clock(clock), .reset(reset), .start(start_n), .funct3(f3_n),
    .op_a(a_n), .op_b(b_n), .flush(flush_n),
    .busy(busy_n), .done(done_n), .result(res_n)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } item_t;

  item_t       q_w[$];
  item_t       q_n[$];
  int          done_cyc_w[$];
  logic [31:0] last_w = '0;
  logic [31:0] last_n = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: whole-number arithmetic on wide integers
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] ai,
                                         input logic [31:0] bi, input int w);
    logic [31:0]         m;
    logic [31:0]         a;
    logic [31:0]         b;
    logic signed [129:0] ua, ub, sa, sb, p;
    logic [31:0]         r;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    a  = ai & m;
    b  = bi & m;
    ua = $signed({98'd0, a});
    ub = $signed({98'd0, b});
    sa = a[w-1] ? ua - (130'sd1 <<< w) : ua;
    sb = b[w-1] ? ub - (130'sd1 <<< w) : ub;
    p  = '0;
    case (f)
      F_MUL:    p = ua * ub;
      F_MULH:   p = (sa * sb) >>> w;
      F_MULHSU: p = (sa * ub) >>> w;
      F_MULHU:  p = (ua * ub) >>> w;
      F_DIV:    p = (b == 0) ? -130'sd1 : sa / sb;
      F_DIVU:   p = (b == 0) ? -130'sd1 : ua / ub;
      F_REM:    p = (b == 0) ? ua : sa % sb;
      default:  p = (b == 0) ? ua : ua % ub;
    endcase
    r = p[31:0];
    return r & m;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'd1 << (w - 1);
      3:       return 32'd1;
      4:       return $urandom_range(0, 15);
      default: return $urandom & m;
    endcase
  endfunction

  always @(negedge clock) begin
    item_t it;
    if (!reset && done_w) begin
      done_cyc_w.push_back(cyc);
      if (q_w.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done32: got result %h expected no done", res_w);
      end else begin
        it = q_w.pop_front();
        check("result32", res_w, it.exp);
        check("latency32", 32'(cyc - it.acc), 32'd33);
        check("busy_at_done32", {31'd0, busy_w}, 32'd1);
        last_w = it.exp;
      end
    end
  end

  always @(negedge clock) begin
    item_t it;
    if (!reset && done_n) begin
      if (q_n.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done8: got result %h expected no done", res_n);
      end else begin
        it = q_n.pop_front();
        check("result8", {24'd0, res_n}, it.exp);
        check("latency8", 32'(cyc - it.acc), 32'd9);
        check("busy_at_done8", {31'd0, busy_n}, 32'd1);
        last_n = it.exp;
      end
    end
  end

  // Waits until the unit can accept (idle or its done cycle), presents one
  // request and, if push is set, queues the expected result.
  task automatic issue(input bit n8, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input bit push, input logic [31:0] exp);
    int    guard;
    item_t it;
    guard = 0;
    @(negedge clock);
    while (n8 ? (busy_n && !done_n) : (busy_w && !done_w)) begin
      guard++;
      if (guard > 200) begin
        total++; bad++;
        $display("FAIL issue_timeout: busy still 1 after 200 cycles, expected 0");
        return;
      end
      @(negedge clock);
    end
    if (n8) begin
      start_n = 1'b1; f3_n = f; a_n = a[7:0]; b_n = b[7:0];
    end else begin
      start_w = 1'b1; f3_w = f; a_w = a; b_w = b;
    end
    @(negedge clock);
    start_n = 1'b0;
    start_w = 1'b0;
    if (n8) begin
      a_n = $urandom; b_n = $urandom; f3_n = 3'($urandom);
      check("busy_after_accept8", {31'd0, busy_n}, 32'd1);
    end else begin
      a_w = $urandom; b_w = $urandom; f3_w = 3'($urandom);
      check("busy_after_accept32", {31'd0, busy_w}, 32'd1);
    end
    if (push) begin
      it.exp = exp;
      it.acc = cyc;
      if (n8) q_n.push_back(it);
      else    q_w.push_back(it);
    end
  endtask

  task automatic wait_idle(input bit n8);
    int guard;
    guard = 0;
    while (n8 ? busy_n : busy_w) begin
      guard++;
      if (guard > 200) begin
        total++; bad++;
        $display("FAIL idle_timeout: busy still 1 after 200 cycles, expected 0");
        return;
      end
      @(negedge clock);
    end
  endtask

  // one operation, also counting how many cycles busy stays high
  task automatic timed_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int n;
    issue(0, f, a, b, 1, exp);
    n = 1;
    while (n < 100) begin
      @(negedge clock);
      if (busy_w) n++;
      else break;
    end
    check("busy_cycles32", 32'(n), 32'd34);
  endtask

  task automatic rand_op(input bit n8);
    logic [2:0]  f;
    logic [31:0] a, b;
    int          w;
    w = n8 ? 8 : 32;
    f = 3'($urandom_range(0, 7));
    a = pick(w);
    b = pick(w);
    issue(n8, f, a, b, 1, model(f, a, b, w));
  endtask

  initial begin
    reset   = 1'b1;
    start_w = 1'b0; flush_w = 1'b0; f3_w = '0; a_w = '0; b_w = '0;
    start_n = 1'b0; flush_n = 1'b0; f3_n = '0; a_n = '0; b_n = '0;
    repeat (3) @(negedge clock);
    check("reset_busy32",   {31'd0, busy_w}, 32'd0);
    check("reset_done32",   {31'd0, done_w}, 32'd0);
    check("reset_result32", res_w, 32'd0);
    check("reset_result8",  {24'd0, res_n}, 32'd0);
    reset = 1'b0;

    // multiply
    timed_op(F_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    timed_op(F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    timed_op(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    timed_op(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // divide
    timed_op(F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    timed_op(F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    timed_op(F_DIVU, 32'd100,       32'd7, 32'd14);
    timed_op(F_REMU, 32'd100,       32'd7, 32'd2);
    // corners
    timed_op(F_DIVU, 32'd17,        32'd0,         32'hFFFF_FFFF);
    timed_op(F_REM,  32'd17,        32'd0,         32'd17);
    timed_op(F_DIV,  32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF);
    timed_op(F_REM,  32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0);
    timed_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    timed_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // start while busy is ignored
    issue(0, F_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD);
    repeat (4) @(negedge clock);
    start_w = 1'b1; f3_w = F_MUL; a_w = 32'd3; b_w = 32'd3;
    @(negedge clock);
    start_w = 1'b0;
    @(negedge clock);
    wait_idle(0);

    // back-to-back: one completion per 34 cycles
    done_cyc_w.delete();
    issue(0, F_MUL,  32'd11,  32'd13, 1, 32'd143);
    issue(0, F_DIVU, 32'd143, 32'd11, 1, 32'd13);
    issue(0, F_MULH, 32'hFFFF_FFFF, 32'd5, 1, 32'hFFFF_FFFF);
    issue(0, F_REMU, 32'd50,  32'd9,  1, 32'd5);
    @(negedge clock);
    wait_idle(0);
    check("b2b_count", 32'(done_cyc_w.size()), 32'd4);
    for (int i = 1; i < done_cyc_w.size(); i++)
      check("b2b_spacing", 32'(done_cyc_w[i] - done_cyc_w[i-1]), 32'd34);

    // flush at CALC cycle 10
    issue(0, F_MUL, 32'h1234, 32'h5678, 0, '0);
    repeat (9) @(negedge clock);
    flush_w = 1'b1;
    @(negedge clock);
    flush_w = 1'b0;
    check("flush_busy",   {31'd0, busy_w}, 32'd0);
    check("flush_result", res_w, last_w);
    repeat (45) @(negedge clock);
    check("flush_result_hold", res_w, last_w);

    // flush and start together while idle: nothing accepted
    start_w = 1'b1; flush_w = 1'b1; f3_w = F_DIVU; a_w = 32'd9; b_w = 32'd3;
    @(negedge clock);
    start_w = 1'b0; flush_w = 1'b0;
    check("flush_start_busy", {31'd0, busy_w}, 32'd0);
    repeat (40) @(negedge clock);

    // XLEN = 8
    issue(1, F_DIV,   32'h80, 32'hFF, 1, 32'h80);
    issue(1, F_MUL,   32'h10, 32'h10, 1, 32'h00);
    issue(1, F_MULHU, 32'h10, 32'h10, 1, 32'h01);
    issue(1, F_REM,   32'hF9, 32'h02, 1, 32'hFF);
    for (int i = 0; i < 40; i++) rand_op(1);
    @(negedge clock);
    wait_idle(1);

    // randomized, XLEN = 32
    for (int i = 0; i < 150; i++) rand_op(0);
    @(negedge clock);
    wait_idle(0);

    // asynchronous reset mid-CALC
    issue(0, F_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, '0);
    repeat (8) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("areset_busy32",   {31'd0, busy_w}, 32'd0);
    check("areset_done32",   {31'd0, done_w}, 32'd0);
    check("areset_result32", res_w, 32'd0);
    check("areset_result8",  {24'd0, res_n}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    last_w = '0;
    timed_op(F_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D,
             model(F_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32));
    @(negedge clock);
    wait_idle(0);
    wait_idle(1);

    check("pending32", 32'(q_w.size()), 32'd0);
    check("pending8",  32'(q_n.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
